// File: rtl/dht22_pkg.sv
// dht22_pkg: state encoding, bus timing and checksum helpers shared by the DHT22 emulator and host driver.
package dht22_pkg;

    typedef enum logic [3:0] {
        IDLE, HOST_LOW, HOST_REL, GO_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_e;

    function automatic logic [31:0] t_start(input int unsigned f);
        return 32'(f / 1000);
    endfunction

    function automatic logic [31:0] t_go(input int unsigned f);
        return 32'(f / 50000);
    endfunction

    function automatic logic [31:0] t_resp(input int unsigned f);
        return 32'(f / 12500);
    endfunction

    function automatic logic [31:0] t_blow(input int unsigned f);
        return 32'(f / 20000);
    endfunction

    function automatic logic [31:0] t_b0(input int unsigned f);
        return 32'(f / 40000);
    endfunction

    // 64-bit product so that 7*CLK_FREQ cannot overflow for fast clocks
    function automatic logic [31:0] t_b1(input int unsigned f);
        return 32'(64'(f) * 64'd7 / 64'd100000);
    endfunction

    function automatic logic [7:0] parity(input logic [15:0] h, input logic [15:0] t, input logic inv);
        return (h[15:8] + h[7:0] + t[15:8] + t[7:0]) ^ {8{inv}};
    endfunction

    function automatic logic drives_low(input state_e s);
        return s inside {RESP_LOW, BIT_LOW, END_LOW};
    endfunction

endpackage

// File: rtl/dht22_sensor_emu_if.sv
// dht22_sensor_emu_if: single-wire bus level, frame payload and status of the DHT22 emulator.
interface dht22_sensor_emu_if;
    logic        dht22_in;
    logic        dht22_out;
    logic        dht22_dir;
    logic [15:0] humidity;
    logic [15:0] temperature;
    logic        inject_err;
    logic        busy;
    logic        frame_done;

    modport master (
        output dht22_in, humidity, temperature, inject_err,
        input  dht22_out, dht22_dir, busy, frame_done
    );

    modport slave (
        input  dht22_in, humidity, temperature, inject_err,
        output dht22_out, dht22_dir, busy, frame_done
    );
endinterface

// File: rtl/dht22_sync.sv
// dht22_sync: two-flop synchronizer with configurable reset level.
module dht22_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] ff_q;

    always_ff @(posedge clk) begin
        ff_q <= rst ? {2{RST_VAL}} : {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];
endmodule

// File: rtl/dht22_sensor_emu.sv
// dht22_sensor_emu: answers a host start pulse with a DHT22 response and 40-bit humidity/temperature frame.
module dht22_sensor_emu
    import dht22_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100000000
) (
    input logic                 clk,
    input logic                 rst,
    dht22_sensor_emu_if.slave   bus
);
    localparam logic [31:0] T_START = t_start(CLK_FREQ);
    localparam logic [31:0] T_GO    = t_go(CLK_FREQ);
    localparam logic [31:0] T_RESP  = t_resp(CLK_FREQ);
    localparam logic [31:0] T_BLOW  = t_blow(CLK_FREQ);
    localparam logic [31:0] T_B0    = t_b0(CLK_FREQ);
    localparam logic [31:0] T_B1    = t_b1(CLK_FREQ);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [5:0]  bit_q, bit_d;
    logic [39:0] frame_q, frame_d;
    logic        out_q, busy_q, done_q;
    logic        lvl;
    logic [31:0] t_high;

    dht22_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.dht22_in),
        .q_o (lvl)
    );

    assign t_high = frame_q[6'd39 - bit_q] ? T_B1 : T_B0;

    // Bus level is only consulted in IDLE and HOST_LOW; once answering, the sequence is purely timed.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        case (state_q)
            IDLE:      if (!lvl) state_d = HOST_LOW;
            HOST_LOW:  if (lvl) state_d = (cnt_q >= T_START - 32'd1) ? GO_WAIT : IDLE;
            GO_WAIT:   if (cnt_q == T_GO - 32'd1) begin
                           state_d = RESP_LOW;
                           frame_d = {bus.humidity, bus.temperature,
                                      parity(bus.humidity, bus.temperature, bus.inject_err)};
                       end
            RESP_LOW:  if (cnt_q == T_RESP - 32'd1) state_d = RESP_HIGH;
            RESP_HIGH: if (cnt_q == T_RESP - 32'd1) begin
                           state_d = BIT_LOW;
                           bit_d   = 6'd0;
                       end
            BIT_LOW:   if (cnt_q == T_BLOW - 32'd1) state_d = BIT_HIGH;
            BIT_HIGH:  if (cnt_q == t_high - 32'd1) begin
                           state_d = (bit_q == 6'd39) ? END_LOW : BIT_LOW;
                           bit_d   = (bit_q == 6'd39) ? bit_q : bit_q + 6'd1;
                       end
            END_LOW:   if (cnt_q == T_BLOW - 32'd1) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? 32'd0 : (&cnt_q ? cnt_q : cnt_q + 32'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            out_q   <= !drives_low(state_d);
            busy_q  <= state_d != IDLE;
            done_q  <= (state_q == END_LOW) && (state_d == IDLE);
        end
    end

    assign bus.dht22_out  = out_q;
    assign bus.dht22_dir  = out_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_dht22_sensor_emu.sv
// tb_dht22_sensor_emu: host-side stimulus and frame decoder checked against a behavioural DHT22 model.
module tb_dht22_sensor_emu;
    localparam int unsigned F = 1000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    dht22_sensor_emu_if bus();

    dht22_sensor_emu #(.CLK_FREQ(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) if (bus.frame_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_parity(input int h, input int t, input bit e);
        int s;
        s = ((h / 256) + (h % 256) + (t / 256) + (t % 256)) % 256;
        return e ? 8'(255 - s) : 8'(s);
    endfunction

    // Length of the current run at level lvl, in cycles; ends on the first sample of the next run.
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (bus.dht22_out === lvl && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    // mode: 0 plain, 1 change humidity at bit 5, 2 reset at bit 10, 3 host pulls low across bit 20
    task automatic xfer(input int low_len, input logic [15:0] h, input logic [15:0] t, input bit e, input int mode);
        int n, g, hl, d0;
        logic [39:0] exp, got;
        exp = {h, t, model_parity(int'(h), int'(t), e)};
        got = '0;
        bus.humidity = h;
        bus.temperature = t;
        bus.inject_err = e;
        d0 = done_cnt;
        bus.dht22_in = 1'b0;
        repeat (low_len) @(negedge clk);
        bus.dht22_in = 1'b1;
        g = 0;
        while (bus.dht22_out !== 1'b0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        // two synchronizer flops plus one registered decision, then 20 cycles of go-wait
        check("go_gap", 64'(g), 64'd23);
        run_len(1'b0, n); check("resp_low", 64'(n), 64'd80);
        run_len(1'b1, n); check("resp_high", 64'(n), 64'd80);
        for (int b = 0; b < 40; b++) begin
            if (mode == 2 && b == 10) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_out", 64'(bus.dht22_out), 64'd1);
                check("rst_dir", 64'(bus.dht22_dir), 64'd1);
                check("rst_busy", 64'(bus.busy), 64'd0);
                check("rst_nodone", 64'(done_cnt - d0), 64'd0);
                return;
            end
            if (mode == 1 && b == 5) bus.humidity = ~h;
            if (mode == 3 && b == 20) bus.dht22_in = 1'b0;
            if (mode == 3 && b == 21) bus.dht22_in = 1'b1;
            run_len(1'b0, n); check("bit_low", 64'(n), 64'd50);
            run_len(1'b1, hl);
            got[39-b] = hl > 47;
            check("bit_high", 64'(hl), exp[39-b] ? 64'd70 : 64'd25);
        end
        run_len(1'b0, n); check("end_low", 64'(n), 64'd50);
        check("frame", 64'(got), 64'(exp));
        @(negedge clk);
        check("done_once", 64'(done_cnt - d0), 64'd1);
        check("busy_end", 64'(bus.busy), 64'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic glitch(input int low_len);
        int g, bad, d0;
        bad = 0;
        d0 = done_cnt;
        bus.dht22_in = 1'b0;
        repeat (low_len) begin
            @(negedge clk);
            if (bus.dht22_dir !== 1'b1) bad++;
        end
        bus.dht22_in = 1'b1;
        g = 0;
        while (bus.busy !== 1'b0 && g < 10) begin
            @(negedge clk);
            g++;
        end
        check("glitch_busy_lat", 64'(g <= 3), 64'd1);
        repeat (60) begin
            @(negedge clk);
            if (bus.dht22_dir !== 1'b1) bad++;
        end
        check("glitch_dir", 64'(bad), 64'd0);
        check("glitch_nodone", 64'(done_cnt - d0), 64'd0);
    endtask

    initial begin
        bus.dht22_in = 1'b1;
        bus.humidity = '0;
        bus.temperature = '0;
        bus.inject_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", 64'(bus.dht22_out), 64'd1);
        check("reset_dir", 64'(bus.dht22_dir), 64'd1);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.frame_done), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        check("parity_e2", 64'(model_parity(16'h028C, 16'h0153, 1'b0)), 64'h0E2);
        xfer(1100, 16'h028C, 16'h0153, 1'b0, 0);
        glitch(500);
        glitch(999);
        xfer(1100, 16'h028C, 16'h0153, 1'b1, 0);
        xfer(1000, 16'($urandom), 16'($urandom), 1'b0, 0);
        xfer(1100, 16'($urandom), 16'($urandom), 1'b0, 2);
        repeat (20) @(negedge clk);
        check("post_rst_busy", 64'(bus.busy), 64'd0);
        xfer(1050, 16'h028C, 16'h0153, 1'b0, 0);
        xfer(int'($urandom_range(1000, 1200)), 16'($urandom), 16'($urandom), 1'($urandom), 1);
        xfer(int'($urandom_range(1000, 1200)), 16'($urandom), 16'($urandom), 1'($urandom), 3);
        for (int i = 0; i < 2; i++)
            xfer(int'($urandom_range(1000, 1200)), 16'($urandom), 16'($urandom), 1'($urandom), 0);
        xfer(1100, 16'h01F4, 16'h00FA, 1'b0, 0);
        for (int i = 0; i < 3; i++) glitch(int'($urandom_range(1, 998)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
